// File: rtl/voter_pkg.sv
// -----------------------------------------------------------------------------
// voter_pkg
// Shared constants and elaboration-time helpers for majority_voter_seq.
//   DEFAULT_FAULT_LIMIT : default number of consecutive disagreeing valid
//                         samples that latch a channel's fault flag
//   cnt_width()         : width of a counter that must hold 0..limit
//   ch_lo()             : low bit index of a channel inside the packed bus
// Optional feature macro used by the voter: VOTER_FAULT_MASK_EN.
// -----------------------------------------------------------------------------
package voter_pkg;

   localparam int DEFAULT_FAULT_LIMIT = 4;

   // Counter must reach the limit value itself, hence limit+1 states.
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

   // Channel ch occupies bits [ch*width +: width] of the packed input bus.
   function automatic int ch_lo(input int ch, input int width);
      return ch * width;
   endfunction

endpackage

// File: rtl/majority_bit.sv
// -----------------------------------------------------------------------------
// majority_bit
// Combinational single-bit majority across N_CH channels.
//   ch_bits : one bit from every channel
//   vote_en : 1 = channel takes part in the vote
//   prev    : previous voted bit, returned on an exact tie
//   vote    : 1 when more than half of the voting channels have a 1
// With every channel enabled and N_CH odd a tie is impossible; ties only
// arise when faulty channels are masked out (VOTER_FAULT_MASK_EN). When no
// channel votes, 0*2 == 0 is treated as a tie, so prev is held.
// -----------------------------------------------------------------------------
module majority_bit #(
   parameter int N_CH = 3
) (
   input  logic [N_CH-1:0] ch_bits,
   input  logic [N_CH-1:0] vote_en,
   input  logic            prev,
   output logic            vote
);

   // Enough bits to count N_CH, plus one more for the doubled ones count.
   localparam int PW = $clog2(N_CH + 1) + 1;

   logic [PW-1:0] ones;
   logic [PW-1:0] voters;
   logic [PW:0]   ones_x2;
   logic [PW:0]   voters_ext;

   always_comb begin
      ones   = '0;
      voters = '0;
      for (int i = 0; i < N_CH; i++) begin
         ones   = ones + PW'(ch_bits[i] & vote_en[i]);
         voters = voters + PW'(vote_en[i]);
      end
      ones_x2    = {ones, 1'b0};
      voters_ext = {1'b0, voters};
      if (ones_x2 > voters_ext) begin
         vote = 1'b1;
      end else if (ones_x2 == voters_ext) begin
         vote = prev;
      end else begin
         vote = 1'b0;
      end
   end

endmodule

// File: rtl/majority_voter_seq.sv
// -----------------------------------------------------------------------------
// majority_voter_seq
// Registered N_CH-way bitwise majority voter with per-channel disagreement
// tracking and sticky fault flags.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset, overrides every other input
//   in_valid  : in_data carries a sample this cycle
//   in_data   : N_CH*WIDTH bus, channel i at [i*WIDTH +: WIDTH]
//   clr_fault : one-cycle pulse clearing all fault flags and counters
//   out_valid : out_data was updated from the previous cycle's sample
//   out_data  : voted word
//   disagree  : channel i differed from the vote on the last valid sample
//   fault     : sticky flag, FAULT_LIMIT consecutive disagreeing samples
//   all_agree : every channel was equal on the last valid sample
// Optional feature macro VOTER_FAULT_MASK_EN: faulty channels leave the
// vote, ties hold the previous output bit, masked channels' counters freeze.
// Without it the fault flags are report-only.
// -----------------------------------------------------------------------------
module majority_voter_seq
   import voter_pkg::*;
#(
   parameter int N_CH        = 3,
   parameter int WIDTH       = 1,
   parameter int FAULT_LIMIT = DEFAULT_FAULT_LIMIT,
   parameter int CNT_W       = cnt_width(FAULT_LIMIT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic                 clr_fault,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [N_CH-1:0]      disagree,
   output logic [N_CH-1:0]      fault,
   output logic                 all_agree
);

   logic             out_valid_reg;
   logic [WIDTH-1:0] out_data_reg;
   logic [WIDTH-1:0] out_data_next;
   logic [N_CH-1:0]  disagree_reg;
   logic [N_CH-1:0]  disagree_next;
   logic [N_CH-1:0]  fault_reg;
   logic [N_CH-1:0]  fault_next;
   logic             all_agree_reg;
   logic             all_agree_next;
   logic [N_CH-1:0]  vote_en;
   logic [N_CH-1:0]  ch_equal;
   logic [N_CH-1:0]  cnt_at_limit;

`ifdef VOTER_FAULT_MASK_EN
   assign vote_en = ~fault_reg;
`else
   assign vote_en = '1;
`endif

   genvar gi, gj;

   // One majority slice per output bit; each gathers that bit from every channel.
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [N_CH-1:0] col;
         for (gj = 0; gj < N_CH; gj++) begin : g_col
            assign col[gj] = in_data[ch_lo(gj, WIDTH) + gi];
         end
         majority_bit #(
            .N_CH (N_CH)
         ) u_majority_bit (
            .ch_bits (col),
            .vote_en (vote_en),
            .prev    (out_data_reg[gi]),
            .vote    (out_data_next[gi])
         );
      end
   endgenerate

   // Per-channel comparison against the fresh vote plus disagreement counter.
   generate
      for (gj = 0; gj < N_CH; gj++) begin : g_ch
         logic [WIDTH-1:0] ch_data;
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;

         assign ch_data           = in_data[ch_lo(gj, WIDTH) +: WIDTH];
         assign disagree_next[gj] = |(ch_data ^ out_data_next);
         assign ch_equal[gj]      = (ch_data == in_data[WIDTH-1:0]);

         // Clear wins over increment; masked channels keep their count.
         always_comb begin
            cnt_next = cnt_reg;
            if (clr_fault) begin
               cnt_next = '0;
            end else if (in_valid && vote_en[gj]) begin
               if (disagree_next[gj]) begin
                  if (cnt_reg != CNT_W'(FAULT_LIMIT)) begin
                     cnt_next = cnt_reg + CNT_W'(1);
                  end
               end else begin
                  cnt_next = '0;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_next;
            end
         end

         // Fault sets on the same edge the counter arrives at the limit.
         assign cnt_at_limit[gj] = (cnt_next == CNT_W'(FAULT_LIMIT));
      end
   endgenerate

   assign fault_next     = clr_fault ? '0 : (fault_reg | cnt_at_limit);
   // With every channel masked nothing was voted, so agreement is not claimed.
   assign all_agree_next = (&ch_equal) & (|vote_en);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         disagree_reg  <= '0;
         all_agree_reg <= 1'b0;
         fault_reg     <= '0;
      end else begin
         out_valid_reg <= in_valid;
         if (in_valid) begin
            out_data_reg  <= out_data_next;
            disagree_reg  <= disagree_next;
            all_agree_reg <= all_agree_next;
         end
         fault_reg <= fault_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign disagree  = disagree_reg;
   assign fault     = fault_reg;
   assign all_agree = all_agree_reg;

endmodule

// File: tb/tb_majority_voter_seq.sv
// -----------------------------------------------------------------------------
// tb_majority_voter_seq
// Bench for majority_voter_seq with N_CH=3, WIDTH=4, FAULT_LIMIT=4.
// Directed vector table first, then randomized traffic against a reference
// model. Honours VOTER_FAULT_MASK_EN when defined for the build.
// -----------------------------------------------------------------------------
module tb_majority_voter_seq;

   localparam int N_CH        = 3;
   localparam int WIDTH       = 4;
   localparam int FAULT_LIMIT = 4;
   localparam int N_VEC       = 31;
   localparam int N_RAND      = 300;

`ifdef VOTER_FAULT_MASK_EN
   localparam bit MASK_EN = 1'b1;
`else
   localparam bit MASK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [11:0] in_data;
   logic        clr_fault;
   logic        out_valid;
   logic [3:0]  out_data;
   logic [2:0]  disagree;
   logic [2:0]  fault;
   logic        all_agree;

   always #5 clk = ~clk;

   majority_voter_seq #(
      .N_CH        (N_CH),
      .WIDTH       (WIDTH),
      .FAULT_LIMIT (FAULT_LIMIT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .clr_fault (clr_fault),
      .out_valid (out_valid),
      .out_data  (out_data),
      .disagree  (disagree),
      .fault     (fault),
      .all_agree (all_agree)
   );

   typedef struct {
      logic        r;
      logic        v;
      logic        c;
      logic [11:0] d;
      logic        ev;
      logic [3:0]  ed;
      logic [2:0]  edis;
      logic [2:0]  ef;
      logic        ea;
   } vec_t;

   vec_t tbl [N_VEC];

   int errors = 0;
   int checks = 0;

   // Reference model state: what the consumer should observe.
   logic       m_ov;
   logic [3:0] m_od;
   logic [2:0] m_dis;
   logic [2:0] m_fault;
   logic       m_ag;
   int         m_cnt [3];

   function automatic logic [11:0] pk(input logic [3:0] c0, input logic [3:0] c1,
                                      input logic [3:0] c2);
      return {c2, c1, c0};
   endfunction

   function automatic vec_t mk(input logic r, input logic v, input logic c,
                               input logic [11:0] d, input logic ev,
                               input logic [3:0] ed, input logic [2:0] edis,
                               input logic [2:0] ef, input logic ea);
      vec_t t;
      t.r = r; t.v = v; t.c = c; t.d = d;
      t.ev = ev; t.ed = ed; t.edis = edis; t.ef = ef; t.ea = ea;
      return t;
   endfunction

   // Behavioural model: count ones per bit among voting channels and compare
   // against half the voter count; counters are plain integers.
   task automatic model_step(input logic r, input logic v, input logic c,
                             input logic [11:0] d);
      logic [3:0] ch [3];
      logic [3:0] nd;
      bit   [2:0] masked;
      int         ones;
      int         voters;
      if (r) begin
         m_ov = 0; m_od = '0; m_dis = '0; m_fault = '0; m_ag = 0;
         for (int i = 0; i < 3; i++) m_cnt[i] = 0;
         return;
      end
      voters = 0;
      for (int i = 0; i < 3; i++) begin
         ch[i]     = d[i*4 +: 4];
         masked[i] = MASK_EN && m_fault[i];
         if (!masked[i]) voters++;
      end
      m_ov = v;
      if (v) begin
         nd = m_od;
         for (int b = 0; b < 4; b++) begin
            ones = 0;
            for (int i = 0; i < 3; i++) if (!masked[i] && ch[i][b]) ones++;
            if (2 * ones > voters)      nd[b] = 1'b1;
            else if (2 * ones < voters) nd[b] = 1'b0;
         end
         m_od = nd;
         for (int i = 0; i < 3; i++) m_dis[i] = (ch[i] != nd);
         m_ag = (ch[0] == ch[1]) && (ch[1] == ch[2]) && (voters > 0);
         for (int i = 0; i < 3; i++) begin
            if (!masked[i]) begin
               if (m_dis[i]) m_cnt[i] = (m_cnt[i] < FAULT_LIMIT) ? m_cnt[i] + 1 : FAULT_LIMIT;
               else          m_cnt[i] = 0;
            end
            if (m_cnt[i] == FAULT_LIMIT) m_fault[i] = 1'b1;
         end
      end
      if (c) begin
         m_fault = '0;
         for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic c, input logic [11:0] d);
      rst = r; in_valid = v; clr_fault = c; in_data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int idx, input logic ev,
                        input logic [3:0] ed, input logic [2:0] edis,
                        input logic [2:0] ef, input logic ea);
      checks++;
      if ({out_valid, out_data, disagree, fault, all_agree} !== {ev, ed, edis, ef, ea}) begin
         errors++;
         $display("FAIL %s[%0d] got v=%b d=%h dis=%b f=%b ag=%b expected v=%b d=%h dis=%b f=%b ag=%b",
                  tag, idx, out_valid, out_data, disagree, fault, all_agree,
                  ev, ed, edis, ef, ea);
      end else begin
         $display("ok   %s[%0d] rst=%b v=%b clr=%b in=%h -> v=%b d=%h dis=%b f=%b ag=%b",
                  tag, idx, rst, in_valid, clr_fault, in_data,
                  out_valid, out_data, disagree, fault, all_agree);
      end
   endtask

   initial begin
      logic [3:0]  od16;
      logic [2:0]  dis16;
      logic        r, v, c;
      logic [11:0] d;
      logic [3:0]  base;

      rst = 1'b1; in_valid = 1'b0; clr_fault = 1'b0; in_data = '0;

      od16  = MASK_EN ? 4'hA : 4'hF;
      dis16 = MASK_EN ? 3'b111 : 3'b010;

      // Reset held with live input, then release.
      tbl[0]  = mk(1, 1, 0, pk(4'h1, 4'h2, 4'h3), 0, 4'h0, 3'b000, 3'b000, 0);
      tbl[1]  = mk(1, 1, 0, pk(4'hF, 4'h0, 4'h5), 0, 4'h0, 3'b000, 3'b000, 0);
      tbl[2]  = mk(0, 0, 0, pk(4'hF, 4'h0, 4'h5), 0, 4'h0, 3'b000, 3'b000, 0);
      // ch2 disagrees four times with idle gaps; fault only after the 4th.
      tbl[3]  = mk(0, 1, 0, pk(4'hA, 4'hA, 4'h5), 1, 4'hA, 3'b100, 3'b000, 0);
      tbl[4]  = mk(0, 0, 0, pk(4'h0, 4'h0, 4'h0), 0, 4'hA, 3'b100, 3'b000, 0);
      tbl[5]  = mk(0, 1, 0, pk(4'hA, 4'hA, 4'h5), 1, 4'hA, 3'b100, 3'b000, 0);
      tbl[6]  = mk(0, 0, 0, pk(4'h0, 4'h0, 4'h0), 0, 4'hA, 3'b100, 3'b000, 0);
      tbl[7]  = mk(0, 1, 0, pk(4'hA, 4'hA, 4'h5), 1, 4'hA, 3'b100, 3'b000, 0);
      tbl[8]  = mk(0, 0, 0, pk(4'h0, 4'h0, 4'h0), 0, 4'hA, 3'b100, 3'b000, 0);
      tbl[9]  = mk(0, 1, 0, pk(4'hA, 4'hA, 4'h5), 1, 4'hA, 3'b100, 3'b100, 0);
      // Clear together with a still-disagreeing sample; re-arm takes 4 more.
      tbl[10] = mk(0, 1, 1, pk(4'h3, 4'h3, 4'hC), 1, 4'h3, 3'b100, 3'b000, 0);
      tbl[11] = mk(0, 1, 0, pk(4'h3, 4'h3, 4'hC), 1, 4'h3, 3'b100, 3'b000, 0);
      tbl[12] = mk(0, 1, 0, pk(4'h3, 4'h3, 4'hC), 1, 4'h3, 3'b100, 3'b000, 0);
      tbl[13] = mk(0, 1, 0, pk(4'h3, 4'h3, 4'hC), 1, 4'h3, 3'b100, 3'b000, 0);
      tbl[14] = mk(0, 1, 0, pk(4'h3, 4'h3, 4'hC), 1, 4'h3, 3'b100, 3'b100, 0);
      // Masking: prime out_data=0xA, then a 2-voter tie when ch2 is masked.
      tbl[15] = mk(0, 1, 0, pk(4'hA, 4'hA, 4'hA), 1, 4'hA, 3'b000, 3'b100, 1);
      tbl[16] = mk(0, 1, 0, pk(4'hF, 4'h0, 4'hF), 1, od16, dis16,  3'b100, 0);
      tbl[17] = mk(0, 0, 1, pk(4'h0, 4'h0, 4'h0), 0, od16, dis16,  3'b000, 0);
      // ch1 heads toward a fault; reset lands on the would-be setting edge.
      tbl[18] = mk(0, 1, 0, pk(4'h5, 4'hA, 4'h5), 1, 4'h5, 3'b010, 3'b000, 0);
      tbl[19] = mk(0, 1, 0, pk(4'h5, 4'hA, 4'h5), 1, 4'h5, 3'b010, 3'b000, 0);
      tbl[20] = mk(0, 1, 0, pk(4'h5, 4'hA, 4'h5), 1, 4'h5, 3'b010, 3'b000, 0);
      tbl[21] = mk(1, 1, 0, pk(4'h5, 4'hA, 4'h5), 0, 4'h0, 3'b000, 3'b000, 0);
      tbl[22] = mk(0, 0, 0, pk(4'h5, 4'hA, 4'h5), 0, 4'h0, 3'b000, 3'b000, 0);
      // Three disagreements, an agreeing sample, then four more to fault.
      tbl[23] = mk(0, 1, 0, pk(4'h5, 4'hA, 4'h5), 1, 4'h5, 3'b010, 3'b000, 0);
      tbl[24] = mk(0, 1, 0, pk(4'h5, 4'hA, 4'h5), 1, 4'h5, 3'b010, 3'b000, 0);
      tbl[25] = mk(0, 1, 0, pk(4'h5, 4'hA, 4'h5), 1, 4'h5, 3'b010, 3'b000, 0);
      tbl[26] = mk(0, 1, 0, pk(4'h5, 4'h5, 4'h5), 1, 4'h5, 3'b000, 3'b000, 1);
      tbl[27] = mk(0, 1, 0, pk(4'h5, 4'hA, 4'h5), 1, 4'h5, 3'b010, 3'b000, 0);
      tbl[28] = mk(0, 1, 0, pk(4'h5, 4'hA, 4'h5), 1, 4'h5, 3'b010, 3'b000, 0);
      tbl[29] = mk(0, 1, 0, pk(4'h5, 4'hA, 4'h5), 1, 4'h5, 3'b010, 3'b000, 0);
      tbl[30] = mk(0, 1, 0, pk(4'h5, 4'hA, 4'h5), 1, 4'h5, 3'b010, 3'b010, 0);

      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < N_VEC; i++) begin
         drive(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].d);
         check("dir", i, tbl[i].ev, tbl[i].ed, tbl[i].edis, tbl[i].ef, tbl[i].ea);
      end

      // Randomized traffic; channels mostly copy a common word so that
      // counters build up and faults, clears and resets interleave.
      model_step(1'b1, 1'b0, 1'b0, '0);
      drive(1'b1, 1'b0, 1'b0, '0);
      check("rst", 0, m_ov, m_od, m_dis, m_fault, m_ag);
      for (int n = 0; n < N_RAND; n++) begin
         r    = ($urandom_range(63) == 0);
         v    = ($urandom_range(3) != 0);
         c    = ($urandom_range(15) == 0);
         base = 4'($urandom);
         for (int i = 0; i < 3; i++) begin
            d[i*4 +: 4] = ($urandom_range(3) == 0) ? 4'($urandom) : base;
         end
         model_step(r, v, c, d);
         drive(r, v, c, d);
         check("rnd", n, m_ov, m_od, m_dis, m_fault, m_ag);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/majority_voter_seq.md
Name: majority_voter_seq

Overview:
- Parametrised, registered successor to the team's 3-input combinational voter.
- Takes N_CH redundant channels of WIDTH bits each and computes a bitwise majority.
- Tracks per-channel disagreement with saturating counters and latches sticky fault flags.
- Sits between redundant sensor/logic copies and downstream consumers; output is registered, with a valid qualifier.

Parameters:
- N_CH, 3, number of redundant channels; odd, at least 3.
- WIDTH, 1, bits per channel.
- FAULT_LIMIT, 4, consecutive disagreeing valid samples that set a channel's fault flag; at least 1.
- CNT_W, $clog2(FAULT_LIMIT+1), disagreement counter width (derived).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  in_data sample is valid this cycle
- in_data  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- clr_fault  in  1  one-cycle pulse clearing all fault flags and counters
- out_valid  out  1  out_data updated from the previous cycle's sample
- out_data  out  WIDTH  voted result
- disagree  out  N_CH  channel i differed from the vote on the last valid sample
- fault  out  N_CH  sticky per-channel fault flag
- all_agree  out  1  all channels equal on the last valid sample

Behaviour:
- Reset: rst=1 at a clock edge zeroes out_valid, out_data, disagree, fault, all_agree and all counters. rst overrides every other input.
- Vote: each bit is 1 when the number of voting channels with a 1 in that bit is greater than half the voting count.
  - Without the optional feature, all N_CH channels vote, so ties cannot occur.
- Latency: 1 cycle. A sample with in_valid=1 at edge k gives out_data, out_valid=1, disagree and all_agree after edge k.
- in_valid=0: out_valid=0 next cycle. out_data, disagree, all_agree and counters hold.
- Counters, per channel, on a valid sample:
  - If the channel differs from the vote in any bit, its counter increments, saturating at FAULT_LIMIT.
  - Otherwise its counter clears to 0.
- Fault: set in the same edge that the counter reaches FAULT_LIMIT. Stays set until clr_fault or rst.
- clr_fault with in_valid in the same cycle: the vote, disagree and out_data update normally. Counters and fault clear; clear wins over increment.
- No backpressure: the output is sampled by the consumer every cycle.

Optional Feature:
- Macro: VOTER_FAULT_MASK_EN.
- Defined:
  - Channels with fault=1 are excluded from the vote.
  - Per bit, if ones*2 equals the voting count, the previous out_data bit is held.
  - If every channel is faulty, out_data holds, out_valid still follows in_valid, and all_agree=0.
  - disagree is still reported for masked channels; their counters freeze.
- Undefined: fault is report-only; every channel always votes.

Decomposition:
- Package voter_pkg holds:
  - the localparam functions for CNT_W and the channel slice index;
  - a constant for the default FAULT_LIMIT.
- One natural sub-module, majority_bit: N_CH input bits plus an N_CH voting-enable mask and the previous bit in; voted bit out.
  - Instantiated WIDTH times through generate.
  - Purely combinational popcount and compare; all state stays in the top.

Test Plan (N_CH=3, WIDTH=4, FAULT_LIMIT=4):
- Reset: rst=1 for 2 cycles with in_valid=1 and random in_data -> all outputs 0 throughout and after release.
- Single disagreement: ch0=0xA, ch1=0xA, ch2=0x5, in_valid=1 for 1 cycle -> next cycle out_data=0xA, out_valid=1, disagree=3'b100, all_agree=0. Following idle cycle -> out_valid=0, out_data stays 0xA.
- Fault threshold:
  - ch2 disagrees on 4 valid samples separated by idle gaps -> fault[2]=1 after the 4th sample's edge, not before.
  - Repeat with an agreeing sample after the 3rd -> counter cleared, fault stays 0.
- Clear collision: fault=3'b100, then clr_fault=1 with in_valid=1 and ch2 still disagreeing -> fault=0, counter[2]=0, disagree[2]=1. A fault needs 4 further disagreeing samples to reappear.
- Masking (fault[2]=1, previous out_data=0xA), sample ch0=0xF, ch1=0x0, ch2=0xF:
  - with VOTER_FAULT_MASK_EN -> out_data=0xA (tie holds);
  - without -> out_data=0xF.
- Mid-operation reset: rst=1 in the cycle fault[1] would set -> fault=0, counters 0, out_valid=0 next cycle.
